// File: rtl/c16_ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 clock, then
// assembles 11-bit frames (start, 8 data LSB first, odd parity, stop) into scancodes.
module c16_ps2_receiver #(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       receiveflag,
    output logic       error
);
    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_IDLE,
        ST_RECV
    } state_t;

    logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    scancode_q, scancode_d;
    logic          rflag_q, rflag_d;
    logic          err_q, err_d;
    logic          sample;
    logic          bit_in;

    always_comb begin
        clk_s1_d = ps2_clk;
        clk_s2_d = clk_s1_q;
        dat_s1_d = ps2_data;
        dat_s2_d = dat_s1_q;

        // The filtered level flips on the FILTER-th consecutive opposite sample.
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == FW'(FILTER - 1)) begin
                filt_d = ~filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end

        sample = filt_q & ~filt_d;
        bit_in = dat_s2_q;

        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tmo_d      = tmo_q;
        scancode_d = scancode_q;
        rflag_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sample && !bit_in) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = 4'd1;
                    tmo_d     = '0;
                    shift_d   = '0;
                    parity_d  = 1'b0;
                end
            end
            ST_RECV: begin
                if (sample) begin
                    tmo_d = '0;
                    if (bit_cnt_q <= 4'd8) begin
                        shift_d   = {bit_in, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (bit_cnt_q == 4'd9) begin
                        parity_d  = bit_in;
                        bit_cnt_d = 4'd10;
                    end else begin
                        // Stop bit: accept only with stop=1 and odd parity over data+parity.
                        if (bit_in && (^{shift_q, parity_q})) begin
                            scancode_d = shift_q;
                            rflag_d    = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d   = ST_IDLE;
                        bit_cnt_d = 4'd0;
                    end
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 4'd0;
                    shift_d   = '0;
                    parity_d  = 1'b0;
                    tmo_d     = '0;
                    err_d     = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            scancode_q <= 8'h00;
            rflag_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_s1_q   <= clk_s1_d;
            clk_s2_q   <= clk_s2_d;
            dat_s1_q   <= dat_s1_d;
            dat_s2_q   <= dat_s2_d;
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_q      <= tmo_d;
            scancode_q <= scancode_d;
            rflag_q    <= rflag_d;
            err_q      <= err_d;
        end
    end

    assign scancode    = scancode_q;
    assign receiveflag = rflag_q;
    assign error       = err_q;

endmodule

// File: tb/tb_c16_ps2_receiver.sv
// Self-checking bench for c16_ps2_receiver: PS/2 frames driven bit by bit,
// outcomes predicted from frame content (parity/stop rules) and compared per scenario.
module tb_c16_ps2_receiver;
    localparam int FILT = 8;
    localparam int TMO  = 400;
    localparam int HALF = 42;   // ~12 kHz PS/2 clock with a 1 MHz system clock

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       receiveflag;
    logic       error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fall = 0;
    int rf_cnt = 0;
    int err_cnt = 0;
    int rf_cyc = 0;
    int err_cyc = 0;
    bit mon_en = 0;
    logic prev_rf = 0;
    logic prev_err = 0;
    logic [7:0] obs_q[$];
    logic [7:0] exp_q[$];

    c16_ps2_receiver #(.FILTER(FILT), .TIMEOUT(TMO)) dut (
        .clk(clk),
        .reset(reset),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .scancode(scancode),
        .receiveflag(receiveflag),
        .error(error)
    );

    // clock / reset block
    initial begin
        clk = 0;
        forever #500 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // strobe monitor: records pulses, checks exclusivity and single-cycle width
    always @(negedge clk) begin
        if (mon_en) begin
            if (receiveflag === 1'b1) begin
                rf_cnt++;
                rf_cyc = cyc;
                obs_q.push_back(scancode);
            end
            if (error === 1'b1) begin
                err_cnt++;
                err_cyc = cyc;
            end
            checks++;
            if ((receiveflag & error) || (receiveflag & prev_rf) || (error & prev_err)) begin
                errors++;
                $display("FAIL strobe_shape cyc=%0d rf=%b err=%b prev_rf=%b prev_err=%b",
                         cyc, receiveflag, error, prev_rf, prev_err);
            end
            prev_rf  = receiveflag;
            prev_err = error;
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] build_frame(input logic [7:0] b, input logic flip,
                                                input logic stop);
        logic [10:0] f;
        f[0]   = 1'b0;
        f[8:1] = b;
        f[9]   = ~(^b) ^ flip;
        f[10]  = stop;
        return f;
    endfunction

    // Reference rule: accepted iff stop is 1 and data+parity hold an odd number of ones.
    function automatic bit frame_ok(input logic [7:0] b, input logic par, input logic stop);
        return (stop == 1'b1) && ((($countones(b) + int'(par)) % 2) == 1);
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (i == glitch_at) begin
                tick(10);
                ps2_clk = 0;
                tick(FILT - 2);
                ps2_clk = 1;
                tick(HALF - 10 - (FILT - 2));
            end else begin
                tick(HALF);
            end
            ps2_clk   = 0;
            last_fall = cyc;
            tick(HALF);
            ps2_clk = 1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip, input logic stop,
                              input int glitch_at);
        logic [10:0] f;
        f = build_frame(b, flip, stop);
        if (frame_ok(b, f[9], stop)) exp_q.push_back(b);
        send_bits(f, 11, glitch_at);
        ps2_data = 1;
        tick(HALF);
    endtask

    task automatic test_reset;
        reset    = 1;
        ps2_clk  = 1;
        ps2_data = 1;
        tick(3);
        checks++;
        if (scancode !== 8'h00) begin errors++; $display("FAIL reset_scancode got %0h want 00", scancode); end
        checks++;
        if (receiveflag !== 1'b0) begin errors++; $display("FAIL reset_rflag got %b want 0", receiveflag); end
        checks++;
        if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
        reset = 0;
        tick(20);
        mon_en = 1;
        checks++;
        if (scancode !== 8'h00) begin errors++; $display("FAIL idle_scancode got %0h want 00", scancode); end
        checks++;
        if (receiveflag !== 1'b0 || error !== 1'b0) begin
            errors++; $display("FAIL idle_strobes got rf=%b err=%b want 0 0", receiveflag, error);
        end
    endtask

    task automatic test_valid_frame;
        int rf0, e0, lat;
        rf0 = rf_cnt; e0 = err_cnt;
        send_frame(8'h1C, 0, 1, -1);
        tick(20);
        lat = rf_cyc - last_fall;
        checks++;
        if (rf_cnt - rf0 !== 1) begin errors++; $display("FAIL valid_rf_count got %0d want 1", rf_cnt - rf0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL valid_err_count got %0d want 0", err_cnt - e0); end
        checks++;
        if (scancode !== 8'h1C) begin errors++; $display("FAIL valid_scancode got %0h want 1c", scancode); end
        checks++;
        if (lat < FILT + 2 || lat > FILT + 3) begin
            errors++; $display("FAIL valid_latency got %0d want %0d..%0d", lat, FILT + 2, FILT + 3);
        end
    endtask

    task automatic test_back_to_back;
        obs_q.delete();
        exp_q.delete();
        send_frame(8'hF0, 0, 1, -1);
        send_frame(8'h1C, 0, 1, -1);
        tick(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_code[%0d] got %0h want %0h", i,
                         (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (scancode !== 8'h1C) begin errors++; $display("FAIL b2b_final got %0h want 1c", scancode); end
    endtask

    task automatic test_parity_error;
        int rf0, e0, lat;
        send_frame(8'h45, 0, 1, -1);
        rf0 = rf_cnt; e0 = err_cnt;
        send_frame(8'h1C, 1, 1, -1);
        tick(20);
        lat = err_cyc - last_fall;
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL parity_err_count got %0d want 1", err_cnt - e0); end
        checks++;
        if (rf_cnt - rf0 !== 0) begin errors++; $display("FAIL parity_rf_count got %0d want 0", rf_cnt - rf0); end
        checks++;
        if (scancode !== 8'h45) begin errors++; $display("FAIL parity_scancode got %0h want 45", scancode); end
        checks++;
        if (lat < FILT + 2 || lat > FILT + 3) begin
            errors++; $display("FAIL parity_latency got %0d want %0d..%0d", lat, FILT + 2, FILT + 3);
        end
    endtask

    task automatic test_bad_stop;
        int rf0, e0;
        rf0 = rf_cnt; e0 = err_cnt;
        send_frame(8'h3A, 0, 0, -1);
        tick(20);
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL stop_err_count got %0d want 1", err_cnt - e0); end
        checks++;
        if (rf_cnt - rf0 !== 0) begin errors++; $display("FAIL stop_rf_count got %0d want 0", rf_cnt - rf0); end
        checks++;
        if (scancode !== 8'h45) begin errors++; $display("FAIL stop_scancode got %0h want 45", scancode); end
    endtask

    task automatic test_timeout;
        int rf0, e0, dly;
        rf0 = rf_cnt; e0 = err_cnt;
        send_bits(build_frame(8'hA7, 0, 1), 5, -1);
        ps2_data = 1;
        tick(TMO + 60);
        dly = err_cyc - last_fall;
        checks++;
        if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err_count got %0d want 1", err_cnt - e0); end
        checks++;
        if (rf_cnt - rf0 !== 0) begin errors++; $display("FAIL timeout_rf_count got %0d want 0", rf_cnt - rf0); end
        checks++;
        if (dly < TMO || dly > TMO + FILT + 6) begin
            errors++; $display("FAIL timeout_delay got %0d want %0d..%0d", dly, TMO, TMO + FILT + 6);
        end
        send_frame(8'h29, 0, 1, -1);
        tick(20);
        checks++;
        if (scancode !== 8'h29) begin errors++; $display("FAIL timeout_next_code got %0h want 29", scancode); end
        checks++;
        if (rf_cnt - rf0 !== 1 || err_cnt - e0 !== 1) begin
            errors++; $display("FAIL timeout_next_counts got rf=%0d err=%0d want 1 1", rf_cnt - rf0, err_cnt - e0);
        end
    endtask

    task automatic test_glitch;
        int rf0, e0;
        rf0 = rf_cnt; e0 = err_cnt;
        ps2_data = 0;
        ps2_clk  = 0;
        tick(FILT - 2);
        ps2_clk = 1;
        tick(30);
        ps2_data = 1;
        tick(10);
        checks++;
        if (rf_cnt - rf0 !== 0 || err_cnt - e0 !== 0) begin
            errors++; $display("FAIL glitch_idle got rf=%0d err=%0d want 0 0", rf_cnt - rf0, err_cnt - e0);
        end
        send_frame(8'h5A, 0, 1, 4);
        tick(20);
        checks++;
        if (scancode !== 8'h5A) begin errors++; $display("FAIL glitch_code got %0h want 5a", scancode); end
        checks++;
        if (rf_cnt - rf0 !== 1) begin errors++; $display("FAIL glitch_rf_count got %0d want 1", rf_cnt - rf0); end
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_err_count got %0d want 0", err_cnt - e0); end
    endtask

    task automatic test_reset_mid_frame;
        int rf0, e0;
        rf0 = rf_cnt; e0 = err_cnt;
        send_bits(build_frame(8'h66, 0, 1), 5, -1);
        tick(HALF / 2);
        reset = 1;
        tick(1);
        reset = 0;
        tick(HALF);
        send_frame(8'h66, 0, 1, -1);
        tick(20);
        checks++;
        if (err_cnt - e0 !== 0) begin errors++; $display("FAIL rstmid_err_count got %0d want 0", err_cnt - e0); end
        checks++;
        if (rf_cnt - rf0 !== 1) begin errors++; $display("FAIL rstmid_rf_count got %0d want 1", rf_cnt - rf0); end
        checks++;
        if (scancode !== 8'h66) begin errors++; $display("FAIL rstmid_code got %0h want 66", scancode); end
    endtask

    task automatic test_random;
        int e0, exp_err, r;
        logic [7:0] b;
        logic flip, stop, par;
        obs_q.delete();
        exp_q.delete();
        e0 = err_cnt;
        exp_err = 0;
        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom_range(0, 255));
            r    = $urandom_range(0, 7);
            flip = (r <= 1);
            stop = (r != 2);
            par  = (($countones(b) % 2) == 0) ^ flip;
            if (!frame_ok(b, par, stop)) exp_err++;
            send_frame(b, flip, stop, -1);
            tick($urandom_range(0, 40));
        end
        tick(20);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_code[%0d] got %0h want %0h", i,
                         (i < obs_q.size()) ? obs_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (err_cnt - e0 !== exp_err) begin
            errors++; $display("FAIL rand_err_count got %0d want %0d", err_cnt - e0, exp_err);
        end
    endtask

    initial begin
        reset    = 1;
        ps2_clk  = 1;
        ps2_data = 1;
        test_reset();
        test_valid_frame();
        test_back_to_back();
        test_parity_error();
        test_bad_stop();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/c16_ps2_receiver.md
C16_PS2_RECEIVER -- requirements
Module: c16_ps2_receiver

Interface
REQ-001 SHALL have parameter FILTER, default 8: consecutive clk samples at a new level required before filtered ps2_clk changes.
REQ-002 SHALL have parameter TIMEOUT, default 50000: clk cycles allowed between falling edges inside a frame.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ps2_clk  input  1  raw asynchronous PS/2 clock line.
REQ-006 SHALL have port ps2_data  input  1  raw asynchronous PS/2 data line.
REQ-007 SHALL have port scancode  output  8  last valid received byte, feeds the key matrix scancode input.
REQ-008 SHALL have port receiveflag  output  1  one-cycle strobe that scancode has just been updated.
REQ-009 SHALL have port error  output  1  one-cycle strobe on a rejected or aborted frame.

Function
REQ-010 SHALL pass ps2_clk and ps2_data each through a two-flop synchronizer before any other use.
REQ-011 SHALL keep a filtered clock level, reset value 1, that toggles only after FILTER consecutive synchronized samples at the opposite level.
REQ-012 SHALL clear the filter run counter on any sample equal to the current filtered level.
REQ-013 SHALL treat a 1-to-0 transition of the filtered clock as a sample point and capture synchronized ps2_data in that same cycle.
REQ-014 SHALL run a two-state FSM: IDLE and RECV.
REQ-015 IDLE: a sample point with data 0 (start bit) SHALL move to RECV with bit counter 1.
REQ-016 IDLE: a sample point with data 1 SHALL be ignored, with no state change and no error.
REQ-017 RECV SHALL shift bits 1-8 into the data register LSB first, take bit 9 as parity and bit 10 as stop.
REQ-018 On the stop-bit sample, the frame SHALL be valid only if stop=1 and the ones count of data plus parity is odd.
REQ-019 On a valid frame: scancode SHALL load the data byte and receiveflag SHALL pulse high for exactly one cycle; both take effect on the clk edge after the stop-bit sample point (latency 1).
REQ-020 On an invalid frame: error SHALL pulse for one cycle with the same latency, scancode SHALL be unchanged and receiveflag SHALL stay low.
REQ-021 After the stop bit, the FSM SHALL return to IDLE regardless of validity.
REQ-022 RECV SHALL run a timeout counter that clears on every sample point and increments otherwise.
REQ-023 When the timeout counter reaches TIMEOUT, the FSM SHALL return to IDLE, discard partial data and pulse error once.
REQ-024 If a sample point and timeout-reach coincide, the sample point SHALL win: the counter clears and no abort occurs.
REQ-025 scancode SHALL hold its value indefinitely between valid frames.
REQ-026 receiveflag and error SHALL never both be high, and neither SHALL stay high two consecutive cycles.
REQ-027 F0/E0 prefix bytes SHALL be delivered as ordinary scancodes; interpreting them is downstream's job.
REQ-028 The timeout counter SHALL be wide enough to hold TIMEOUT without wrap-around.

Reset
REQ-029 While reset is high at a clk edge, the block SHALL set scancode=0x00, receiveflag=0, error=0, FSM=IDLE, filtered clock=1, and clear the bit, filter and timeout counters and the data register.
REQ-030 Reset mid-frame SHALL discard the partial frame without an error pulse; the next start bit SHALL begin a fresh frame.
REQ-031 Synchronizer flops SHALL reset to 1, the idle bus level.

Verification
REQ-032 Valid frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) at about 12 kHz -> scancode=0x1C, exactly one receiveflag pulse one cycle after the stop-bit sample point, error stays 0.
REQ-033 Frame 0x1C with parity=1 -> exactly one error pulse, no receiveflag, scancode keeps its prior value.
REQ-034 Frames 0xF0 then 0x1C back to back -> two receiveflag pulses with scancode 0xF0 then 0x1C.
REQ-035 Five bits sent, then lines idle longer than TIMEOUT cycles -> one error pulse at the timeout; a following valid 0x29 frame -> scancode=0x29 with one receiveflag pulse.
REQ-036 A ps2_clk low glitch of FILTER-2 clk cycles in IDLE or mid-frame -> no bit is taken; a following valid 0x5A frame decodes correctly.
REQ-037 reset asserted for one cycle after bit 4 of a frame, then a full valid 0x66 frame -> no error pulse, scancode=0x66, one receiveflag pulse.
